// File: rtl/bf16_add_arbiter.sv
// Round-robin front end sharing one pipelined BF16 adder among NUM_REQ requesters.
// Response follows accept by ADD_LATENCY+1 edges; combinational grant, no response backpressure.
module bf16_add_arbiter #(
  parameter int SIZE_DATA   = 16,
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 2,
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_a,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_b,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic                         i_hold,
  output logic [SIZE_DATA-1:0]         o_add_a,
  output logic [SIZE_DATA-1:0]         o_add_b,
  input  logic [SIZE_DATA-1:0]         i_add_s,
  output logic                         o_rsp_valid,
  output logic [SIZE_DATA-1:0]         o_rsp_data,
  output logic [IDW-1:0]               o_rsp_id,
  output logic                         o_busy
);

  logic [IDW-1:0]       r_rr_ptr;
  logic [ADD_LATENCY:0] r_tag_vld;
  logic [IDW-1:0]       r_tag_id [ADD_LATENCY+1];

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDW-1:0]       w_gnt_id;
  logic                 w_found;
  logic                 w_accept;
  logic [IDW:0]         w_idx;
  logic [SIZE_DATA-1:0] w_sel_a;
  logic [SIZE_DATA-1:0] w_sel_b;
  logic [IDW-1:0]       w_next_ptr;

  // Search from r_rr_ptr upward; the extra index bit absorbs the wrap before the modulo.
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(i);
      if (w_idx >= (IDW+1)'(NUM_REQ)) begin
        w_idx = w_idx - (IDW+1)'(NUM_REQ);
      end
      if (!w_found && i_req_valid[w_idx[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx[IDW-1:0];
      end
    end
    if (w_found && !i_hold && i_rst_n) begin
      w_grant[w_gnt_id] = 1'b1;
    end
  end

  assign o_req_ready = w_grant;
  assign w_accept    = |w_grant;

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt_id == IDW'(k)) begin
        w_sel_a = i_req_a[k*SIZE_DATA +: SIZE_DATA];
        w_sel_b = i_req_b[k*SIZE_DATA +: SIZE_DATA];
      end
    end
  end

  assign w_next_ptr = (w_gnt_id == IDW'(NUM_REQ-1)) ? '0 : w_gnt_id + IDW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr <= '0;
      o_add_a  <= '0;
      o_add_b  <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_next_ptr;
      o_add_a  <= w_sel_a;
      o_add_b  <= w_sel_b;
    end
  end

  // Tag shift register mirrors the adder pipeline; it never stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_vld <= '0;
      for (int s = 0; s <= ADD_LATENCY; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_vld   <= {r_tag_vld[ADD_LATENCY-1:0], w_accept};
      r_tag_id[0] <= w_gnt_id;
      for (int s = 1; s <= ADD_LATENCY; s++) begin
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_id    <= '0;
    end else begin
      o_rsp_valid <= r_tag_vld[ADD_LATENCY];
      if (r_tag_vld[ADD_LATENCY]) begin
        o_rsp_data <= i_add_s;
        o_rsp_id   <= r_tag_id[ADD_LATENCY];
      end
    end
  end

  assign o_busy = (|r_tag_vld) | o_rsp_valid;

endmodule

// File: tb/tb_bf16_add_arbiter.sv
// Directed bench for bf16_add_arbiter with a two-stage registered adder model.
module tb_bf16_add_arbiter;
  localparam int SD  = 16;
  localparam int NR  = 4;
  localparam int AL  = 2;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*SD-1:0]  req_a;
  logic [NR*SD-1:0]  req_b;
  logic [NR-1:0]     req_ready;
  logic              hold;
  logic [SD-1:0]     add_a;
  logic [SD-1:0]     add_b;
  logic [SD-1:0]     add_s;
  logic              rsp_valid;
  logic [SD-1:0]     rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
  logic [SD-1:0]     s1;
  logic [SD-1:0]     s2;

  int n_cmp = 0;
  int n_bad = 0;

  bf16_add_arbiter #(.SIZE_DATA(SD), .NUM_REQ(NR), .ADD_LATENCY(AL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_a(req_a),
    .i_req_b(req_b), .o_req_ready(req_ready), .i_hold(hold), .o_add_a(add_a),
    .o_add_b(add_b), .i_add_s(add_s), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_rsp_id(rsp_id), .o_busy(busy)
  );

  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3F80 && b == 16'h4000) return 16'h4040;
    if (a == 16'h4040 && b == 16'h3F80) return 16'h4080;
    return a ^ b;
  endfunction

  always @(posedge clk) begin
    s1 <= model_add(add_a, add_b);
    s2 <= s1;
  end
  assign add_s = s2;

  task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b);
    req_a[k*SD +: SD] = a;
    req_b[k*SD +: SD] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold = 1'b0; req_valid = 4'hF; req_a = '0; req_b = '0;
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (add_a !== 16'h0 || add_b !== 16'h0) begin n_bad++; $display("FAIL reset_add got %h/%h want 0000/0000", add_a, add_b); end
    n_cmp++; if (rsp_data !== 16'h0 || rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_rsp got %h id %0d want 0000 id 0", rsp_data, rsp_id); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_op(2, 16'h3F80, 16'h4000);
    req_valid = 4'b0100; #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got %b want 0100", req_ready); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      req_valid = 4'b0000; #1;
      if (c == 1) begin
        n_cmp++; if (add_a !== 16'h3F80 || add_b !== 16'h4000) begin n_bad++; $display("FAIL single_operands got %h/%h want 3f80/4000", add_a, add_b); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", busy); end
      end
      n_cmp++; if (rsp_valid !== (c == 4)) begin n_bad++; $display("FAIL single_rsp_valid cycle %0d got %b want %b", c, rsp_valid, (c == 4)); end
      if (c >= 4) begin
        n_cmp++; if (rsp_data !== 16'h4040 || rsp_id !== 2'd2) begin n_bad++; $display("FAIL single_rsp cycle %0d got %h id %0d want 4040 id 2", c, rsp_data, rsp_id); end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_rr_wrap();
    logic [3:0] exp_rdy [3];
    exp_rdy = '{4'b1000, 4'b0001, 4'b1000};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 4'b1001; #1;
      n_cmp++; if (req_ready !== exp_rdy[c]) begin n_bad++; $display("FAIL wrap_ready step %0d got %b want %b", c, req_ready, exp_rdy[c]); end
    end
    req_valid = 4'b0000;
    for (int c = 3; c <= 7; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid !== (c == 4 || c == 5)) begin n_bad++; $display("FAIL wrap_rsp_valid cycle %0d got %b", c, rsp_valid); end
      if (c == 4 || c == 5) begin
        n_cmp++; if (rsp_id !== ((c == 4) ? 2'd3 : 2'd0)) begin n_bad++; $display("FAIL wrap_rsp_id cycle %0d got %0d want %0d", c, rsp_id, (c == 4) ? 3 : 0); end
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    req_valid = 4'hF; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL hold_pre_ready0 got %b want 0010", req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL hold_pre_ready1 got %b want 0100", req_ready); end
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      hold = 1'b1; #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL hold_ready cycle %0d got %b want 0000", c, req_ready); end
      n_cmp++; if (rsp_valid !== (c == 4 || c == 5)) begin n_bad++; $display("FAIL hold_rsp_valid cycle %0d got %b", c, rsp_valid); end
      if (c == 4 || c == 5) begin
        n_cmp++; if (rsp_id !== ((c == 4) ? 2'd1 : 2'd2)) begin n_bad++; $display("FAIL hold_rsp_id cycle %0d got %0d", c, rsp_id); end
      end
      if (c >= 5) begin
        n_cmp++; if (busy !== (c == 5)) begin n_bad++; $display("FAIL hold_busy cycle %0d got %b want %b", c, busy, (c == 5)); end
      end
    end
    @(negedge clk);
    hold = 1'b0; #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL hold_release_ready got %b want 1000", req_ready); end
    req_valid = 4'h0;
  endtask

  task automatic test_reset_midflight();
    int pulses;
    @(negedge clk);
    req_valid = 4'hF;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'hF; #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL midrst_ready got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_valid_busy got %b/%b want 0/0", rsp_valid, busy); end
    n_cmp++; if (add_a !== 16'h0 || add_b !== 16'h0 || rsp_data !== 16'h0 || rsp_id !== 2'd0) begin n_bad++; $display("FAIL midrst_regs got %h %h %h %0d want zeros", add_a, add_b, rsp_data, rsp_id); end
    @(negedge clk);
    req_valid = 4'h0; rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (rsp_valid === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_pulses got %0d want 0", pulses); end
  endtask

  task automatic test_contention();
    logic [15:0] exp_d [4];
    exp_d = '{16'h1111, 16'h1222, 16'h1444, 16'h1888};
    set_op(0, 16'h1001, 16'h0110);
    set_op(1, 16'h1002, 16'h0220);
    set_op(2, 16'h1004, 16'h0440);
    set_op(3, 16'h1008, 16'h0880);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      req_valid = (c < 8) ? 4'hF : 4'h0; #1;
      if (c < 8) begin
        n_cmp++; if (req_ready !== (4'b0001 << (c % 4))) begin n_bad++; $display("FAIL cont_ready cycle %0d got %b want %b", c, req_ready, 4'b0001 << (c % 4)); end
      end
      n_cmp++; if (rsp_valid !== (c >= 4 && c < 12)) begin n_bad++; $display("FAIL cont_rsp_valid cycle %0d got %b", c, rsp_valid); end
      if (c >= 4 && c < 12) begin
        n_cmp++; if (rsp_id !== 2'((c - 4) % 4) || rsp_data !== exp_d[(c - 4) % 4]) begin
          n_bad++; $display("FAIL cont_rsp cycle %0d got %h id %0d want %h id %0d", c, rsp_data, rsp_id, exp_d[(c - 4) % 4], (c - 4) % 4);
        end
      end
    end
  endtask

  task automatic test_idle_hold();
    int pulses;
    @(negedge clk);
    set_op(1, 16'h4040, 16'h3F80);
    req_valid = 4'b0010; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL idle_ready got %b want 0010", req_ready); end
    pulses = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      req_valid = 4'h0; #1;
      n_cmp++; if (add_a !== 16'h4040 || add_b !== 16'h3F80) begin n_bad++; $display("FAIL idle_operands cycle %0d got %h/%h want 4040/3f80", c, add_a, add_b); end
      if (rsp_valid === 1'b1) begin
        pulses++;
        n_cmp++; if (rsp_data !== 16'h4080 || rsp_id !== 2'd1) begin n_bad++; $display("FAIL idle_rsp got %h id %0d want 4080 id 1", rsp_data, rsp_id); end
      end
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL idle_pulses got %0d want 1", pulses); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_wrap();
    test_hold();
    test_reset_midflight();
    test_contention();
    test_idle_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
